// File: rtl/difftest_pkg.sv
// Shared types and constants for the difftest commit path.
// Provides the retire record layout carried from the core to the checker,
// the GPR file geometry and the architectural reset PC.
package difftest_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned NR_GPR    = 32;
  localparam int unsigned GPR_IDX_W = 5;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      npc;
    logic                 wen;
    logic [GPR_IDX_W-1:0] rd;
    logic [XLEN-1:0]      wdata;
  } commit_rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and no read-to-write bypass.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push, wdata    write request and payload (ignored while full)
//   pop, rdata     read request (ignored while empty) and head payload
//   full, empty    occupancy flags, derived from registered pointers
//   count          number of stored entries
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit separates the full and empty cases when the indices match.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset: slots are only observed after being written.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/difftest_commit_queue.sv
// Producer side of the difftest GPR/PC interface.
// Retire events are queued and handed to the checker one per handshake; each pop
// commits the record into a shadow GPR file, the snapshot PC and the retire counter.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmt_*                     retire event from writeback (valid/ready handshake)
//   dt_valid/dt_ready/dt_*pc  head record offered to the checker
//   snap_valid, snap_pc       one-cycle pulse after a pop, npc of that record
//   rf_raddr, rf_rdata        combinational shadow GPR read
//   retire_cnt                records popped since reset
//   overflow                  sticky flag: push attempted while full
module difftest_commit_queue #(
  parameter int unsigned      DEPTH    = 4,
  parameter int unsigned      XLEN     = difftest_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = difftest_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmt_valid,
  output logic            cmt_ready,
  input  logic [XLEN-1:0] cmt_pc,
  input  logic [XLEN-1:0] cmt_npc,
  input  logic            cmt_wen,
  input  logic [4:0]      cmt_rd,
  input  logic [XLEN-1:0] cmt_wdata,
  output logic            dt_valid,
  input  logic            dt_ready,
  output logic [XLEN-1:0] dt_pc,
  output logic [XLEN-1:0] dt_npc,
  output logic            snap_valid,
  output logic [XLEN-1:0] snap_pc,
  input  logic [4:0]      rf_raddr,
  output logic [XLEN-1:0] rf_rdata,
  output logic [63:0]     retire_cnt,
  output logic            overflow
);
  import difftest_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  commit_rec_t     push_rec, head_rec;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic            push, pop;

  logic [XLEN-1:0] gpr_q [NR_GPR];
  logic [XLEN-1:0] snap_pc_q;
  logic            snap_valid_q;
  logic [63:0]     retire_cnt_q;
  logic            overflow_q;

  always_comb begin
    push_rec       = '0;
    push_rec.pc    = cmt_pc;
    push_rec.npc   = cmt_npc;
    push_rec.wen   = cmt_wen;
    push_rec.rd    = cmt_rd;
    push_rec.wdata = cmt_wdata;
  end

  assign cmt_ready = !fifo_full;
  assign dt_valid  = (fifo_count != '0);
  assign push      = cmt_valid && cmt_ready;
  assign pop       = dt_ready && !fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(commit_rec_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_rec),
    .pop   (pop),
    .rdata (head_rec),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign dt_pc  = head_rec.pc;
  assign dt_npc = head_rec.npc;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_GPR; i++) gpr_q[i] <= '0;
      snap_pc_q    <= RESET_PC;
      snap_valid_q <= 1'b0;
      retire_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      snap_valid_q <= pop;
      if (cmt_valid && !cmt_ready) overflow_q <= 1'b1;
      if (pop) begin
        // x0 is hardwired: never let a write land in slot 0.
        if (head_rec.wen && (head_rec.rd != '0)) gpr_q[head_rec.rd] <= head_rec.wdata;
        snap_pc_q    <= head_rec.npc;
        retire_cnt_q <= retire_cnt_q + 64'd1;
      end
    end
  end

  assign rf_rdata   = (rf_raddr == '0) ? '0 : gpr_q[rf_raddr];
  assign snap_valid = snap_valid_q;
  assign snap_pc    = snap_pc_q;
  assign retire_cnt = retire_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed self-checking bench for difftest_commit_queue (DEPTH=4, XLEN=32).
module tb_difftest_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmt_valid, cmt_ready;
  logic [31:0] cmt_pc, cmt_npc, cmt_wdata;
  logic        cmt_wen;
  logic [4:0]  cmt_rd;
  logic        dt_valid, dt_ready;
  logic [31:0] dt_pc, dt_npc;
  logic        snap_valid;
  logic [31:0] snap_pc;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic [63:0] retire_cnt;
  logic        overflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] ref_rf [32];
  logic [63:0] exp_retire;
  logic [31:0] last_npc;

  always #5 clk = ~clk;

  difftest_commit_queue #(
    .DEPTH    (4),
    .XLEN     (32),
    .RESET_PC (32'h8000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmt_valid  (cmt_valid),
    .cmt_ready  (cmt_ready),
    .cmt_pc     (cmt_pc),
    .cmt_npc    (cmt_npc),
    .cmt_wen    (cmt_wen),
    .cmt_rd     (cmt_rd),
    .cmt_wdata  (cmt_wdata),
    .dt_valid   (dt_valid),
    .dt_ready   (dt_ready),
    .dt_pc      (dt_pc),
    .dt_npc     (dt_npc),
    .snap_valid (snap_valid),
    .snap_pc    (snap_pc),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .retire_cnt (retire_cnt),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input int idx, input logic [31:0] exp);
    rf_raddr = 5'(idx);
    #1;
    check(tag, {32'd0, rf_rdata}, {32'd0, exp});
  endtask

  // Drives a record and, when it will be accepted, updates the reference model.
  task automatic drive(input logic [31:0] pc, input logic wen, input logic [4:0] rd,
                       input logic [31:0] wd, input logic accepted);
    cmt_valid = 1'b1;
    cmt_pc    = pc;
    cmt_npc   = pc + 32'd4;
    cmt_wen   = wen;
    cmt_rd    = rd;
    cmt_wdata = wd;
    if (accepted) begin
      if (wen && rd != 5'd0) ref_rf[rd] = wd;
      exp_retire = exp_retire + 64'd1;
      last_npc   = pc + 32'd4;
    end
  endtask

  initial begin
    rst = 1'b1; cmt_valid = 1'b0; dt_ready = 1'b0; rf_raddr = 5'd0;
    cmt_pc = '0; cmt_npc = '0; cmt_wen = 1'b0; cmt_rd = '0; cmt_wdata = '0;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    exp_retire = '0;
    last_npc   = 32'h8000_0000;
    tick();
    tick();

    // Reset state
    check("rst_dt_valid", {63'd0, dt_valid}, 64'd0);
    check("rst_cmt_ready", {63'd0, cmt_ready}, 64'd1);
    check("rst_snap_pc", {32'd0, snap_pc}, 64'h8000_0000);
    check("rst_snap_valid", {63'd0, snap_valid}, 64'd0);
    check("rst_retire", retire_cnt, 64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check_rf("rst_rf7", 7, 32'd0);

    // Single push with dt_ready held high: no bypass, pops one cycle later
    rst = 1'b0;
    dt_ready = 1'b1;
    drive(32'h8000_0000, 1'b1, 5'd5, 32'h1234, 1'b1);
    tick();
    cmt_valid = 1'b0;
    check("p1_dt_valid", {63'd0, dt_valid}, 64'd1);
    check("p1_dt_pc", {32'd0, dt_pc}, 64'h8000_0000);
    check("p1_dt_npc", {32'd0, dt_npc}, 64'h8000_0004);
    check("p1_snap_early", {63'd0, snap_valid}, 64'd0);
    check("p1_retire_early", retire_cnt, 64'd0);
    tick();
    check("p1_snap_valid", {63'd0, snap_valid}, 64'd1);
    check("p1_dt_empty", {63'd0, dt_valid}, 64'd0);
    check("p1_snap_pc", {32'd0, snap_pc}, 64'h8000_0004);
    check("p1_retire", retire_cnt, 64'd1);
    check_rf("p1_rf5", 5, 32'h1234);
    tick();
    check("p1_snap_drop", {63'd0, snap_valid}, 64'd0);

    // rd=0 write is discarded
    drive(32'h8000_0004, 1'b1, 5'd0, 32'hDEAD, 1'b1);
    tick();
    cmt_valid = 1'b0;
    tick();
    check("x0_retire", retire_cnt, 64'd2);
    check("x0_snap_pc", {32'd0, snap_pc}, 64'h8000_0008);
    check_rf("x0_rf0", 0, 32'd0);
    check_rf("x0_rf5", 5, 32'h1234);

    // Fill to full with the checker stalled, then overflow
    dt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h8000_0100 + 32'(4 * i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i), i < 4);
      check($sformatf("fill_ready_%0d", i), {63'd0, cmt_ready}, (i < 4) ? 64'd1 : 64'd0);
      check($sformatf("fill_ovf_%0d", i), {63'd0, overflow}, 64'd0);
      tick();
    end
    cmt_valid = 1'b0;
    check("fill_overflow", {63'd0, overflow}, 64'd1);
    dt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_valid_%0d", i), {63'd0, dt_valid}, 64'd1);
      check($sformatf("drain_pc_%0d", i), {32'd0, dt_pc}, {32'd0, 32'h8000_0100 + 32'(4 * i)});
      tick();
    end
    check("drain_empty", {63'd0, dt_valid}, 64'd0);
    check("drain_ready", {63'd0, cmt_ready}, 64'd1);
    check("drain_overflow", {63'd0, overflow}, 64'd1);
    check("drain_retire", retire_cnt, 64'd6);
    check("drain_snap_pc", {32'd0, snap_pc}, 64'h8000_0110);
    check_rf("drain_rf13", 13, 32'hA3);
    check_rf("drain_rf14", 14, 32'd0);

    // Streaming: push every cycle with the checker always ready
    for (int i = 0; i < 100; i++) begin
      drive(32'h9000_0000 + 32'(4 * i), (i % 3) != 0, 5'(i % 32),
            32'h1357_0000 + 32'(i) * 32'h111, 1'b1);
      check($sformatf("stream_ready_%0d", i), {63'd0, cmt_ready}, 64'd1);
      tick();
    end
    cmt_valid = 1'b0;
    for (int k = 0; k < 10 && dt_valid; k++) tick();
    check("stream_drained", {63'd0, dt_valid}, 64'd0);
    check("stream_retire", retire_cnt, exp_retire);
    check("stream_snap_pc", {32'd0, snap_pc}, {32'd0, last_npc});
    for (int r = 0; r < 32; r++) check_rf($sformatf("stream_rf%0d", r), r, ref_rf[r]);

    // Reset mid-operation with a push and a pop requested in the reset cycle
    dt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'hA000_0000 + 32'(4 * i), 1'b1, 5'(1 + i), 32'hFFFF_0000, 1'b0);
      tick();
    end
    check("prerst_valid", {63'd0, dt_valid}, 64'd1);
    drive(32'hB000_0000, 1'b1, 5'd9, 32'h55, 1'b0);
    dt_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmt_valid = 1'b0;
    check("mrst_dt_valid", {63'd0, dt_valid}, 64'd0);
    check("mrst_ready", {63'd0, cmt_ready}, 64'd1);
    check("mrst_retire", retire_cnt, 64'd0);
    check("mrst_overflow", {63'd0, overflow}, 64'd0);
    check("mrst_snap_pc", {32'd0, snap_pc}, 64'h8000_0000);
    check("mrst_snap_valid", {63'd0, snap_valid}, 64'd0);
    for (int r = 0; r < 32; r++) check_rf($sformatf("mrst_rf%0d", r), r, 32'd0);
    tick();
    check("mrst_no_push", {63'd0, dt_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
